// File: rtl/pipeline_pkg.sv
// Shared constants, types and decode helpers for the 3-stage pipeline.
package pipeline_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_LOAD = 3'b001;
  localparam logic [2:0] WB_PC4  = 3'b010;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_ALU  = 2'b01,
    FWD_LOAD = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN       = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic rs1;
    logic rs2;
  } src_use_t;

  // Which register sources an execute-stage opcode actually reads.
  function automatic src_use_t src_use(input logic [6:0] opcode);
    src_use_t u;
    u = '0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR:     u.rs1 = 1'b1;
      OP_REG, OP_STORE, OP_BRANCH: begin
        u.rs1 = 1'b1;
        u.rs2 = 1'b1;
      end
      default:                      u = '0;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Load-use stall, operand forwarding and branch flush control for the
// 3-stage pipeline, with saturating stall/flush performance counters.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter logic [2:0]  WB_SEL_LOAD = 3'b001,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      instruction_execute,
  input  logic [31:0]      instruction_mem,
  input  logic             reg_wr_mem,
  input  logic [2:0]       rd_wr_mem_mem,
  input  logic             mem_ready,
  input  logic             branch_taken_execute,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_fetch,
  output logic             bubble_mem,
  output logic             flush_fetch,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hz_state_t  state_q, state_d;
  logic [4:0] lat_rs1_q, lat_rs1_d;
  logic [4:0] lat_rs2_q, lat_rs2_d;
  logic [4:0] lat_rd_q, lat_rd_d;

  logic [4:0] rs1, rs2, rd_mem;
  src_use_t   uses;
  logic       match_a, match_b, hazard;
  fwd_sel_t   fwd_a, fwd_b;
  logic       unused_fields;

  assign rs1    = instruction_execute[19:15];
  assign rs2    = instruction_execute[24:20];
  assign rd_mem = instruction_mem[11:7];
  assign uses   = src_use(instruction_execute[6:0]);

  // Instruction fields that play no part in hazard detection.
  assign unused_fields = ^{instruction_execute[31:25], instruction_execute[14:7],
                           instruction_mem[31:12], instruction_mem[6:0]};

  assign match_a = reg_wr_mem && (rd_mem != 5'd0) && (rd_mem == rs1) && uses.rs1;
  assign match_b = reg_wr_mem && (rd_mem != 5'd0) && (rd_mem == rs2) && uses.rs2;
  assign hazard  = (match_a || match_b) && (rd_wr_mem_mem == WB_SEL_LOAD);

  // Next state, latches and stall/forward decode from current state and inputs.
  // Only matched source numbers are latched (others as x0); since the load rd
  // is never x0, equality with the latched rd marks a source needing load data.
  always_comb begin
    state_d     = state_q;
    lat_rs1_d   = lat_rs1_q;
    lat_rs2_d   = lat_rs2_q;
    lat_rd_d    = lat_rd_q;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    stall_fetch = 1'b0;
    bubble_mem  = 1'b0;
    case (state_q)
      RUN: begin
        if (hazard) begin
          stall_fetch = 1'b1;
          bubble_mem  = 1'b1;
          state_d     = LOAD_WAIT;
          lat_rs1_d   = match_a ? rs1 : 5'd0;
          lat_rs2_d   = match_b ? rs2 : 5'd0;
          lat_rd_d    = rd_mem;
        end else begin
          fwd_a = match_a ? FWD_ALU : FWD_RF;
          fwd_b = match_b ? FWD_ALU : FWD_RF;
        end
      end
      LOAD_WAIT: begin
        if (!mem_ready) begin
          stall_fetch = 1'b1;
          bubble_mem  = 1'b1;
        end else begin
          fwd_a   = (lat_rs1_q == lat_rd_q) ? FWD_LOAD : FWD_RF;
          fwd_b   = (lat_rs2_q == lat_rd_q) ? FWD_LOAD : FWD_RF;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign forward_a   = fwd_a;
  assign forward_b   = fwd_b;
  assign flush_fetch = branch_taken_execute & ~stall_fetch;

  // State and latched load-use registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= RUN;
      lat_rs1_q <= '0;
      lat_rs2_q <= '0;
      lat_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_rs1_q <= lat_rs1_d;
      lat_rs2_q <= lat_rs2_d;
      lat_rd_q  <= lat_rd_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (stall_fetch),
    .count (stall_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clock (clock),
    .clear (reset),
    .inc   (flush_fetch),
    .count (flush_count)
  );

endmodule

// File: doc/pipeline_hazard_unit.md
# pipeline_hazard_unit

Hazard and forwarding controller for the 3-stage RV32I pipeline (fetch → decode/execute → memory/writeback). It reads the instructions held in the fetch-to-decode and execute-to-memory pipeline registers and drives the control that flows backwards through the pipeline:

- operand forwarding selects for execute;
- stall of the fetch-to-decode register;
- bubble injection into the execute-to-memory register;
- flush of the fetch-to-decode register on a taken branch or jump.

It also keeps saturating stall and flush counters for performance measurement.

## Interface
- `WB_SEL_LOAD` (default `3'b001`): writeback-select encoding that marks a load.
- `CNT_W` (default `32`): width of each performance counter.

Ports:
- `clock`  in  1: the single clock.
- `reset`  in  1: reset is synchronous and active-high; `reset` is sampled on the rising edge of `clock`.
- `instruction_execute`  in  32: instruction in execute (RISC-V fields: rs1 `[19:15]`, rs2 `[24:20]`, opcode `[6:0]`).
- `instruction_mem`  in  32: instruction in memory/writeback (rd `[11:7]`).
- `reg_wr_mem`  in  1: the memory-stage instruction writes the register file.
- `rd_wr_mem_mem`  in  3: writeback select of the memory-stage instruction.
- `mem_ready`  in  1: data memory has load data available this cycle.
- `branch_taken_execute`  in  1: branch/jump resolved taken in execute.
- `forward_a`, `forward_b`  out  2: operand select. `00` = register file, `01` = memory-stage ALU result, `10` = registered load data.
- `stall_fetch`  out  1: hold the fetch-to-decode register and the PC.
- `bubble_mem`  out  1: load NOP (`32'h00000013`, all write enables 0) into the execute-to-memory register.
- `flush_fetch`  out  1: load NOP into the fetch-to-decode register.
- `stall_count`, `flush_count`  out  `CNT_W`: performance counters.

## Operation
**Source-register usage**, decoded from the execute opcode:
- `0110111`, `0010111`, `1101111`: use no sources.
- `0000011`, `0010011`, `1100111`: use rs1 only.
- `0110011`, `0100011`, `1100011`: use rs1 and rs2.
- Any other opcode: uses no sources.

**Match condition.** A source matches when all of the following hold:
- `reg_wr_mem` is 1;
- rd ≠ 0;
- rd equals the source field;
- the execute instruction uses that source.

**Hazard condition.** `hazard` = a match exists AND `rd_wr_mem_mem == WB_SEL_LOAD`.

**State machine (2 states).**
- `RUN`:
  - With no hazard:
    - each matching source forwards `01`, others `00`;
    - `stall_fetch` = 0 and `bubble_mem` = 0.
  - On a hazard:
    - assert `stall_fetch` and `bubble_mem`; forwards are don't-care;
    - next state `LOAD_WAIT`;
    - the matched source numbers and the load rd are latched.
- `LOAD_WAIT`:
  - If `mem_ready` = 0: `stall_fetch` and `bubble_mem` stay 1; remain in `LOAD_WAIT`.
  - If `mem_ready` = 1:
    - each latched matching source forwards `10`;
    - `stall_fetch` = 0 and `bubble_mem` = 0;
    - next state `RUN`.

**Flush.**
- `flush_fetch` = `branch_taken_execute & ~stall_fetch`.
- A branch's taken/not-taken result is ignored while its operands are stale.
- A taken branch in the same cycle as a release from `LOAD_WAIT` flushes normally.

**Counters.**
- `stall_count` increments on every cycle with `stall_fetch` = 1.
- `flush_count` increments on every cycle with `flush_fetch` = 1.
- Both saturate at all-ones (no wrap).

**Reset.**
- State returns to `RUN`; latched registers and both counters clear to 0.
- Outputs after reset: `forward_a` = `forward_b` = `00`; `stall_fetch`, `bubble_mem` and `flush_fetch` = 0.
- The same holds when `reset` is asserted mid-stall.

## Timing
- Forwarding, stall, bubble and flush are combinational from the inputs and the current state, all within the same cycle.
- State, latched registers and counters update on the rising edge of `clock`.
- Load-use penalty:
  - exactly 1 stall cycle when `mem_ready` is already 1 in the cycle after the hazard;
  - otherwise 1 + the number of further cycles `mem_ready` stays low.
- Counters are visible one cycle after the event they count.
- A match on rd = x0 never forwards or stalls.
- When both sources match the same rd, `forward_a` and `forward_b` select identically.

## Structure
- Package `pipeline_pkg`:
  - opcode constants;
  - `NOP_INSTR = 32'h00000013`;
  - writeback-select encodings;
  - `fwd_sel_t` enum (`FWD_RF`, `FWD_ALU`, `FWD_LOAD`);
  - `hz_state_t` enum (`RUN`, `LOAD_WAIT`).
- One natural sub-module: `sat_counter` (parameter `CNT_W`, inputs `inc` and `clear`), instantiated twice.
- Source-use decode is a function in `pipeline_pkg`.

## Test plan
- ALU dependence: `instruction_mem` = `addi x5,x0,7` with `reg_wr_mem` = 1 and wb select `000`; execute = `add x6,x5,x5` → `forward_a` = `forward_b` = `01`, no stall, counters unchanged.
- Load-use, ready memory: mem = `lw x5,0(x1)`; execute = `add x6,x5,x2`; `mem_ready` = 1 in the following cycle →
  - hazard cycle: `stall_fetch` = `bubble_mem` = 1;
  - next cycle: `forward_a` = `10`, `forward_b` = `00`, `stall_fetch` = 0;
  - `stall_count` = 1.
- Load-use, slow memory: same stimulus with `mem_ready` low for 3 cycles → `stall_fetch` high for 4 cycles, then release with `10`; `stall_count` = 4.
- x0 and no-source cases: mem writes x0 and execute reads x0 → `00`, no stall. Mem loads x5 and execute = `lui x5,1` → no stall.
- Branch flush masking:
  - `branch_taken_execute` = 1 in `RUN` with no hazard → `flush_fetch` = 1, `flush_count` +1;
  - `branch_taken_execute` = 1 during `LOAD_WAIT` with `mem_ready` = 0 → `flush_fetch` = 0.
- Reset mid-stall: assert `reset` in `LOAD_WAIT` → next cycle state `RUN`, all outputs 0, `stall_count` = `flush_count` = 0; saturation checked with `CNT_W` = 4 (held at 15 after 20 stalls).
